add_seq: RTL

ADD_SEQ -- requirements
Module: add_seq

---
 rtl/add_seq_pkg.sv | 31 +++
 rtl/add_seq_decode.sv | 21 ++
 rtl/add_seq.sv | 102 ++++++++++
 3 files changed

// File: rtl/add_seq_pkg.sv
// rtl/add_seq_pkg.sv - opcodes, instruction field positions and FSM states for add_seq
package add_seq_pkg;

  localparam int ADR_W = 14;
  localparam int WORD_W = 64;

  localparam int OP_LSB = 0;
  localparam int OP_W = 6;
  localparam int A_LSB = 6;
  localparam int B_LSB = 12;
  localparam int AB_W = 6;
  localparam int D_LSB = 18;
  localparam int D_W = 7;

  localparam logic [OP_W-1:0] OP_ADD = 6'h00;
  localparam logic [OP_W-1:0] OP_HALT = 6'h3F;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    RD_A,
    RD_B,
    WR,
    DONE
  } state_t;

  function automatic logic [OP_W-1:0] get_op(input logic [WORD_W-1:0] word);
    return word[OP_LSB +: OP_W];
  endfunction

endpackage

// File: rtl/add_seq_decode.sv
// rtl/add_seq_decode.sv - splits the instruction register into opcode and word addresses
module add_seq_decode
  import add_seq_pkg::*;
(
  input  logic [WORD_W-1:0] ir,
  output logic [OP_W-1:0]   op,
  output logic [ADR_W-1:0]  a,
  output logic [ADR_W-1:0]  b,
  output logic [ADR_W-1:0]  d
);

  logic unused_ir_hi;

  assign op = get_op(ir);
  assign a  = {{(ADR_W-AB_W){1'b0}}, ir[A_LSB +: AB_W]};
  assign b  = {{(ADR_W-AB_W){1'b0}}, ir[B_LSB +: AB_W]};
  assign d  = {{(ADR_W-D_W){1'b0}}, ir[D_LSB +: D_W]};

  assign unused_ir_hi = ^ir[WORD_W-1:D_LSB+D_W];

endmodule

// File: rtl/add_seq.sv
// rtl/add_seq.sv - tiny memory-to-memory add sequencer (ADD / NOP / HALT)
module add_seq
  import add_seq_pkg::*;
#(
  parameter logic [ADR_W-1:0] PC_START = 14'd0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [ADR_W-1:0]    adr,
  output logic [WORD_W-1:0]   writeData,
  output logic                writeEn,
  input  logic [WORD_W-1:0]   readData,
  output logic                busy,
  output logic                done,
  output logic [15:0]         addCount
);

  state_t             state;
  logic [ADR_W-1:0]   pc;
  logic [WORD_W-1:0]  ir;
  logic [WORD_W-1:0]  op_a;
  logic [WORD_W-1:0]  op_b;
  logic [OP_W-1:0]    unused_ir_op;
  logic [ADR_W-1:0]   dec_a;
  logic [ADR_W-1:0]   dec_b;
  logic [ADR_W-1:0]   dec_d;

  add_seq_decode u_decode (
    .ir (ir),
    .op (unused_ir_op),
    .a  (dec_a),
    .b  (dec_b),
    .d  (dec_d)
  );

  // FETCH branches on the word being captured, so the opcode comes from readData directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= PC_START;
      ir       <= '0;
      op_a     <= '0;
      op_b     <= '0;
      addCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pc    <= PC_START;
            state <= FETCH;
          end
        end
        FETCH: begin
          ir <= readData;
          case (get_op(readData))
            OP_ADD:  state <= RD_A;
            OP_HALT: state <= DONE;
            default: pc <= pc + 1'b1;
          endcase
        end
        RD_A: begin
          op_a  <= readData;
          state <= RD_B;
        end
        RD_B: begin
          op_b  <= readData;
          state <= WR;
        end
        WR: begin
          pc       <= pc + 1'b1;
          addCount <= addCount + 1'b1;
          state    <= FETCH;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state, never on readData or start.
  always_comb begin
    adr       = '0;
    writeData = '0;
    writeEn   = 1'b0;
    case (state)
      FETCH: adr = pc;
      RD_A:  adr = dec_a;
      RD_B:  adr = dec_b;
      WR: begin
        adr       = dec_d;
        writeData = op_a + op_b;
        writeEn   = 1'b1;
      end
      default: adr = '0;
    endcase
  end

  assign busy = (state == FETCH) || (state == RD_A) || (state == RD_B) || (state == WR);
  assign done = (state == DONE);

endmodule
